// File: rtl/seq7_pkg.sv
// seq7_pkg: shared definitions for the 7-state code checker.
//   - the seven legal 4-bit codes, in sequence order
//   - tracker state enum {HUNT, VERIFY, LOCKED}
//   - next_code / code_index / code_legal helpers
package seq7_pkg;

    localparam logic [3:0] C0 = 4'b0000;  // seed, appears once at start
    localparam logic [3:0] C1 = 4'b0010;
    localparam logic [3:0] C2 = 4'b0101;
    localparam logic [3:0] C3 = 4'b0011;
    localparam logic [3:0] C4 = 4'b0100;
    localparam logic [3:0] C5 = 4'b0110;
    localparam logic [3:0] C6 = 4'b0001;  // last of the repeating loop

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic code_legal(input logic [3:0] c);
        logic ok;
        case (c)
            C0, C1, C2, C3, C4, C5, C6: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Successor in the stream; the loop re-enters at C1, never at C0.
    function automatic logic [3:0] next_code(input logic [3:0] c);
        logic [3:0] n;
        case (c)
            C0:      n = C1;
            C1:      n = C2;
            C2:      n = C3;
            C3:      n = C4;
            C4:      n = C5;
            C5:      n = C6;
            C6:      n = C1;
            default: n = C0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] code_index(input logic [3:0] c);
        logic [2:0] i;
        case (c)
            C1:      i = 3'd1;
            C2:      i = 3'd2;
            C3:      i = 3'd3;
            C4:      i = 3'd4;
            C5:      i = 3'd5;
            C6:      i = 3'd6;
            default: i = 3'd0;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/seq7_code_decoder.sv
// seq7_code_decoder: combinational classification of one 4-bit code.
// Ports:
//   code  in  [3:0]  code to classify
//   legal out        code is one of the seven sequence codes
//   idx   out [2:0]  sequence position (0 for 0000 and for illegal codes)
//   nxt   out [3:0]  successor code
module seq7_code_decoder
    import seq7_pkg::*;
(
    input  logic [3:0] code,
    output logic       legal,
    output logic [2:0] idx,
    output logic [3:0] nxt
);

    always_comb begin
        legal = code_legal(code);
        idx   = code_index(code);
        nxt   = next_code(code);
    end

endmodule

// File: rtl/seq7_checker.sv
// seq7_checker: lock-and-flywheel monitor for the 7-state code stream
//   0000 -> {0010,0101,0011,0100,0110,0001} repeating.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   din_vld, din    sample strobe and 4-bit received code
//   locked          tracker is in LOCKED
//   err_pulse       one-cycle flag for a mismatching locked sample
//   err_cnt         saturating count of locked mismatches (cleared only by rst)
//   idx             sequence position of last accepted sample
//   wrap            one-cycle flag: locked 0001 matched
//   lock_loss_cnt   saturating LOCKED->HUNT count (only with SEQ7_CHK_STATS_EN)
// All outputs are registered and change only on din_vld cycles (pulses clear on idle).
module seq7_checker
    import seq7_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSE_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic [3:0]       din,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       idx,
`ifdef SEQ7_CHK_STATS_EN
    output logic [ERR_W-1:0] lock_loss_cnt,
`endif
    output logic             wrap
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSE_N = 4'(LOSE_CNT);

    state_e           state_q, state_d;
    logic [3:0]       exp_q, exp_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [3:0]       miss_q, miss_d;
    logic [2:0]       idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ep_q, ep_d;
    logic             wrap_q, wrap_d;
    logic             lose;

    logic             din_legal, exp_legal;
    logic [2:0]       din_idx, exp_idx;
    logic [3:0]       din_nxt, exp_nxt;

    // Incoming sample and the flywheel prediction are decoded side by side.
    seq7_code_decoder u_din_dec (.code(din),   .legal(din_legal), .idx(din_idx), .nxt(din_nxt));
    seq7_code_decoder u_exp_dec (.code(exp_q), .legal(exp_legal), .idx(exp_idx), .nxt(exp_nxt));

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mcnt_d  = mcnt_q;
        miss_d  = miss_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ep_d    = 1'b0;
        wrap_d  = 1'b0;
        lose    = 1'b0;
        if (din_vld) begin
            case (state_q)
                HUNT: begin
                    if (din_legal) begin
                        exp_d   = din_nxt;
                        mcnt_d  = 4'd1;
                        miss_d  = 4'd0;
                        idx_d   = din_idx;
                        state_d = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (din == exp_q) begin
                        mcnt_d = mcnt_q + 4'd1;
                        exp_d  = din_nxt;
                        idx_d  = din_idx;
                        if (mcnt_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (din_legal) begin
                        // Wrong but plausible code: restart verification from it.
                        exp_d  = din_nxt;
                        mcnt_d = 4'd1;
                        idx_d  = din_idx;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances whether or not the sample matched.
                    // exp_q is always legal here; the fallback only guards a corrupted register.
                    exp_d = exp_legal ? exp_nxt : C1;
                    if (din == exp_q) begin
                        miss_d = 4'd0;
                        idx_d  = din_idx;
                        wrap_d = (din == C6);
                    end else begin
                        ep_d  = 1'b1;
                        err_d = (err_q == '1) ? err_q : err_q + ERR_W'(1);
                        idx_d = exp_idx;
                        if (miss_q + 4'd1 == LOSE_N) begin
                            state_d = HUNT;
                            miss_d  = 4'd0;
                            lose    = 1'b1;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            exp_q   <= C0;
            mcnt_q  <= 4'd0;
            miss_q  <= 4'd0;
            idx_q   <= 3'd0;
            err_q   <= '0;
            ep_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mcnt_q  <= mcnt_d;
            miss_q  <= miss_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ep_q    <= ep_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef SEQ7_CHK_STATS_EN
    logic [ERR_W-1:0] loss_q;
    always_ff @(posedge clk) begin
        if (rst)
            loss_q <= '0;
        else if (lose && loss_q != '1)
            loss_q <= loss_q + ERR_W'(1);
    end
    assign lock_loss_cnt = loss_q;
`else
    logic unused_lose;
    assign unused_lose = lose;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = ep_q;
    assign err_cnt   = err_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;

endmodule
